neuron_seq: RTL

NEURON_SEQ -- requirements
Module: neuron_seq

---
 rtl/nn_pkg.sv | 19 +
 rtl/neuron_seq_term_cnt.sv | 38 +++
 rtl/neuron_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and defaults for the neuron sequencer and its datapath.
package nn_pkg;

  localparam int ACC_W_DEF = 12;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/neuron_seq_term_cnt.sv
// Remaining-term counter: loads the term count, decrements per transfer, flags the last term.
module term_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  // A decrement at zero is held off so the count can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (dec_i && (cnt_q != {LEN_W{1'b0}})) begin
      cnt_d = cnt_q - LEN_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {LEN_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/neuron_seq.sv
// Sequencer for one neuron evaluation: clears the accumulator, streams operand
// pairs into the datapath, then captures and hands off the activated result.
module neuron_seq
  import nn_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_x,
  input  logic             in_w,
  output logic             calc_1,
  output logic             calc_in,
  output logic             calc_en,
  output logic             calc_rst,
  input  logic             agg_out_acted,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             busy
);

  // ACC_W sizes the companion datapath; the sequencer itself is width-agnostic.
  if (ACC_W < 1) begin : g_bad_acc_w
  end

  state_e state_q;
  state_e state_d;
  logic   out_bit_q;
  logic   out_bit_d;
  logic   cnt_load_s;
  logic   xfer_s;
  logic   cnt_last_s;

  term_cnt #(.LEN_W(LEN_W)) u_term_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load_s),
    .len_i  (len),
    .dec_i  (xfer_s),
    .last_o (cnt_last_s)
  );

  always_comb begin
    state_d    = state_q;
    out_bit_d  = out_bit_q;
    cnt_load_s = 1'b0;
    xfer_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (len != {LEN_W{1'b0}})) begin
          cnt_load_s = 1'b1;
          state_d    = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: state_d = ST_ACC;
      ST_ACC: begin
        if (in_valid) begin
          xfer_s = 1'b1;
          if (cnt_last_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      // The datapath has absorbed the last term by now, so its activation is final.
      ST_DRAIN: begin
        out_bit_d = agg_out_acted;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      out_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_bit_q <= out_bit_d;
    end
  end

  // Everything is qualified by rst so a mid-evaluation reset silences the datapath at once.
  assign in_ready  = rst & (state_q == ST_ACC);
  assign calc_en   = rst & xfer_s;
  assign calc_1    = calc_en & in_x;
  assign calc_in   = calc_en & in_w;
  assign calc_rst  = rst & (state_q != ST_CLEAR);
  assign out_valid = rst & (state_q == ST_OUT);
  assign out_bit   = out_bit_q;
  assign busy      = rst & is_busy(state_q);

endmodule
